mem_access_unit: RTL

//  Sequential load/store alignment unit between the EX stage and a word-wide data memory, replacing the combinational byte-mask unit.

---
 rtl/mem_access_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store alignment unit between EX and a word-wide data memory.
// Takes one request at a time, issues one or two memory beats with byte-lane
// masks and lane-shifted store data, then returns sign/zero-extended load data.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned DMEM_AW   = 10,
  parameter bit          SPLIT_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [3:0]         mem_mask,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ack
);

  localparam logic [3:0] OpLw  = 4'd0;
  localparam logic [3:0] OpLh  = 4'd1;
  localparam logic [3:0] OpLb  = 4'd2;
  localparam logic [3:0] OpLhu = 4'd3;
  localparam logic [3:0] OpLbu = 4'd4;
  localparam logic [3:0] OpSw  = 4'd5;
  localparam logic [3:0] OpSh  = 4'd6;
  localparam logic [3:0] OpSb  = 4'd7;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          op_q;
  logic [1:0]          b_q;
  logic [DMEM_AW-1:0]  word_q;
  logic [31:0]         wdata_q;
  logic [31:0]         lo_q;
  logic [31:0]         hi_q;
  logic                cross_q;
  logic                err_q;

  // Access size in bytes; 0 marks an illegal op.
  function automatic logic [2:0] size_of(input logic [3:0] op);
    case (op)
      OpLw, OpSw:         size_of = 3'd4;
      OpLh, OpLhu, OpSh:  size_of = 3'd2;
      OpLb, OpLbu, OpSb:  size_of = 3'd1;
      default:            size_of = 3'd0;
    endcase
  endfunction

  // Request decode, used only in the accepting cycle.
  logic [31:0] req_off;
  logic [2:0]  req_size;
  logic        req_illegal;
  logic        req_cross;
  logic        req_reject;
  logic        accept;
  logic        unused_off_hi;

  assign req_off       = req_addr - BASE_ADDR;
  assign req_size      = size_of(req_op);
  assign req_illegal   = (req_op > OpSb);
  assign req_cross     = (({1'b0, req_off[1:0]} + req_size) > 3'd4);
  assign req_reject    = req_illegal || (req_cross && !SPLIT_EN);
  assign accept        = req_valid && req_ready;
  // Offset bits above the memory window are ignored by design.
  assign unused_off_hi = ^req_off[31:DMEM_AW+2];

  // Decode of the captured request.
  logic [2:0] cur_size;
  logic       cur_store;
  logic       cur_load;
  logic [4:0] lane_shamt;
  logic [5:0] hi_shamt;
  logic [2:0] hi_lanes;
  logic [3:0] lane_ones;

  assign cur_size   = size_of(op_q);
  assign cur_store  = op_q inside {OpSw, OpSh, OpSb};
  assign cur_load   = op_q inside {OpLw, OpLh, OpLb, OpLhu, OpLbu};
  assign lane_shamt = {b_q, 3'b000};
  // Beat 1 carries the bytes that spilled past lane 3.
  assign hi_shamt   = 6'd32 - {1'b0, lane_shamt};
  assign hi_lanes   = {1'b0, b_q} + cur_size - 3'd4;

  // Contiguous low-lane mask for the access size.
  always_comb begin
    lane_ones = 4'b0000;
    case (cur_size)
      3'd1:    lane_ones = 4'b0001;
      3'd2:    lane_ones = 4'b0011;
      3'd4:    lane_ones = 4'b1111;
      default: lane_ones = 4'b0000;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = req_reject ? StResp : StBeat0;
        end
      end
      StBeat0: begin
        if (mem_ack) begin
          state_d = cross_q ? StBeat1 : StResp;
        end
      end
      StBeat1: begin
        if (mem_ack) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'd0;
      b_q     <= 2'd0;
      word_q  <= '0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        b_q     <= req_off[1:0];
        word_q  <= req_off[DMEM_AW+1:2];
        wdata_q <= req_wdata;
        cross_q <= req_cross;
        err_q   <= req_reject;
        // HI stays zero for single-beat loads so the final shift is uniform.
        lo_q    <= 32'd0;
        hi_q    <= 32'd0;
      end
      if (state_q == StBeat0 && mem_ack && cur_load) begin
        lo_q <= mem_rdata;
      end
      if (state_q == StBeat1 && mem_ack && cur_load) begin
        hi_q <= mem_rdata;
      end
    end
  end

  // Memory beat and response outputs, all driven from registered state.
  logic [31:0] load_v;

  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_mask  = 4'b0000;
    mem_wdata = 32'd0;
    load_v    = 32'({hi_q, lo_q} >> lane_shamt);
    case (state_q)
      StBeat0: begin
        mem_en    = 1'b1;
        mem_we    = cur_store;
        mem_addr  = word_q;
        mem_mask  = lane_ones << b_q;
        mem_wdata = wdata_q << lane_shamt;
      end
      StBeat1: begin
        mem_en    = 1'b1;
        mem_we    = cur_store;
        mem_addr  = word_q + DMEM_AW'(1);
        mem_mask  = (4'd1 << hi_lanes) - 4'd1;
        mem_wdata = wdata_q >> hi_shamt;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q) begin
          case (op_q)
            OpLw:    rsp_rdata = load_v;
            OpLh:    rsp_rdata = {{16{load_v[15]}}, load_v[15:0]};
            OpLhu:   rsp_rdata = {16'd0, load_v[15:0]};
            OpLb:    rsp_rdata = {{24{load_v[7]}}, load_v[7:0]};
            OpLbu:   rsp_rdata = {24'd0, load_v[7:0]};
            default: rsp_rdata = 32'd0;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule
